add_seq: RTL and testbench

ADD_SEQ -- requirements
Module: add_seq

---
 rtl/add_pkg.sv | 21 ++
 rtl/add_slice.sv | 17 +
 rtl/add_seq.sv | 124 ++++++++++++
 tb/tb_add_seq.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/add_pkg.sv
// Shared definitions for the slice-serial adder: FSM encoding, default geometry
// and the signed-overflow rule used on the final slice.
package add_pkg;

  localparam int DEFAULT_WIDTH = 6;
  localparam int DEFAULT_WORDS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Two same-signed operands whose sum flips sign have overflowed.
  function automatic logic signed_overflow(input logic a_msb,
                                           input logic b_msb,
                                           input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/add_slice.sv
// One WIDTH-bit ripple slice with carry in/out; purely combinational and reused
// every cycle by add_seq.
module add_slice
  import add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/add_seq.sv
// Multi-cycle N-bit adder: operands are latched on start and summed one
// WIDTH-bit slice per cycle, LSB first, through a single add_slice.
module add_seq
  import add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int WORDS = DEFAULT_WORDS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   cin,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH*WORDS-1:0] sum,
  output logic                   cout,
  output logic                   overflow
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t state, state_nxt;

  // Operands and result viewed as arrays of slices so the slice index selects directly.
  logic [WORDS-1:0][WIDTH-1:0] a_r;
  logic [WORDS-1:0][WIDTH-1:0] b_r;
  logic [WORDS-1:0][WIDTH-1:0] sum_r;
  logic [IDX_W-1:0]            idx;
  logic                        carry;

  logic                        accept;
  logic                        last_slice;
  logic [WIDTH-1:0]            sl_a;
  logic [WIDTH-1:0]            sl_b;
  logic [WIDTH-1:0]            sl_s;
  logic                        sl_cout;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, otherwise paths that skip an assignment infer latches.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_slice) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign last_slice = (idx == LAST_IDX);
  assign sl_a       = a_r[idx];
  assign sl_b       = b_r[idx];

  add_slice #(
    .WIDTH (WIDTH)
  ) u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry),
    .s    (sl_s),
    .cout (sl_cout)
  );

  // cout/overflow are only rewritten on the final slice, so they hold the
  // previous result through IDLE and the early RUN cycles of the next add.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r      <= '0;
      b_r      <= '0;
      sum_r    <= '0;
      idx      <= '0;
      carry    <= 1'b0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_r   <= a;
      b_r   <= b;
      carry <= cin;
      idx   <= '0;
    end else if (state == ST_RUN) begin
      sum_r[idx] <= sl_s;
      carry      <= sl_cout;
      idx        <= idx + IDX_W'(1);
      if (last_slice) begin
        cout     <= sl_cout;
        overflow <= signed_overflow(a_r[WORDS-1][WIDTH-1],
                                    b_r[WORDS-1][WIDTH-1],
                                    sl_s[WIDTH-1]);
      end
    end
  end

  assign sum = sum_r;

endmodule

// File: tb/tb_add_seq.sv
// Scoreboard bench for add_seq: expected results are queued when a start is
// accepted and compared whenever done pulses.
module tb_add_seq;
  import add_pkg::*;

  localparam int WIDTH = 6;
  localparam int WORDS = 4;
  localparam int N     = WIDTH * WORDS;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic         cin   = 1'b0;
  logic [N-1:0] a     = '0;
  logic [N-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;
  logic         overflow;

  typedef struct packed {
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   n_done = 0;

  always #5 clk = ~clk;

  add_seq #(
    .WIDTH (WIDTH),
    .WORDS (WORDS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cin      (cin),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y,
                                 input logic c);
    logic [N:0] t;
    exp_t       e;
    t     = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, c};
    e.sum = t[N-1:0];
    e.cout = t[N];
    e.ovf = (x[N-1] == y[N-1]) && (e.sum[N-1] != x[N-1]);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: every done pulse must consume one queued result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_done++;
      check("busy_at_done", 64'(busy), 64'd0);
      check("pending_result", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("sum", 64'(sum), 64'(mon_e.sum));
        check("cout", 64'(cout), 64'(mon_e.cout));
        check("overflow", 64'(overflow), 64'(mon_e.ovf));
      end
    end
  end

  // Issue one add at the next falling edge and wait (bounded) for its done.
  task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
    int cycles;
    @(negedge clk);
    a     = x;
    b     = y;
    cin   = c;
    start = 1'b1;
    sb.push_back(model(x, y, c));
    @(negedge clk);
    start  = 1'b0;
    a      = N'($urandom());
    b      = N'($urandom());
    cin    = 1'b1;
    cycles = 1;
    check("busy_in_run", 64'(busy), 64'd1);
    while (done !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    check("latency", 64'(cycles), 64'(WORDS + 1));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_sum"}, 64'(sum), 64'd0);
    check({tag, "_cout"}, 64'(cout), 64'd0);
    check({tag, "_overflow"}, 64'(overflow), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    int d0;

    // Reset state
    repeat (2) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;

    // Carry ripples out of slice 0 into slice 1; latency measured in run_op
    run_op(24'h00003F, 24'h000001, 1'b0);

    // Extra starts during RUN and DONE are ignored
    @(negedge clk);
    a     = '0;
    b     = '0;
    cin   = 1'b1;
    start = 1'b1;
    sb.push_back(model(24'h0, 24'h0, 1'b1));
    d0 = n_done;
    repeat (5) begin
      @(negedge clk);
      a     = N'($urandom());
      b     = N'($urandom());
      cin   = 1'b0;
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("single_done", 64'(n_done - d0), 64'd1);
    check("hold_sum", 64'(sum), 64'h000001);
    check("idle_not_busy", 64'(busy), 64'd0);

    // Carry out of the MSB and signed overflow corners
    run_op(24'hFFFFFF, 24'h000001, 1'b0);
    run_op(24'h7FFFFF, 24'h000001, 1'b0);
    run_op(24'h800000, 24'h800000, 1'b0);

    // Reset in the third RUN cycle aborts with no done
    @(negedge clk);
    a     = 24'hFFFFFF;
    b     = 24'hFFFFFF;
    cin   = 1'b1;
    start = 1'b1;
    d0    = n_done;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_cleared("abort");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("no_done_after_abort", 64'(n_done - d0), 64'd0);
    run_op(24'h123456, 24'h111111, 1'b0);

    // Random back-to-back sweep
    for (int i = 0; i < 30; i++) begin
      run_op(N'($urandom()), N'($urandom()), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
